// File: rtl/zbuf_pkg.sv
// Shared types for the Z-buffer depth-test block: FSM state encoding, default
// geometry and the packed fragment layout produced by the fragment FIFO.
package zbuf_pkg;

  localparam int X_W_DEF = 8;
  localparam int Y_W_DEF = 8;
  localparam int Z_W_DEF = 16;
  localparam int C_W_DEF = 24;

  localparam logic [Z_W_DEF-1:0] Z_FAR = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_DATA,
    ST_ZREAD,
    ST_ZCMP,
    ST_WRITE,
    ST_CLEAR
  } state_e;

  // Default-geometry fragment; x occupies the LSBs.
  typedef struct packed {
    logic [C_W_DEF-1:0] color;
    logic [Z_W_DEF-1:0] z;
    logic [Y_W_DEF-1:0] y;
    logic [X_W_DEF-1:0] x;
  } frag_t;

endpackage

// File: rtl/zbuffer_depth_test_if.sv
// FIFO pop port plus Z-memory and frame-buffer ports of the depth-test block.
// master = depth-test block, slave = FIFO/memory side.
interface zbuffer_depth_test_if #(
  parameter int X_W = 8,
  parameter int Y_W = 8,
  parameter int Z_W = 16,
  parameter int C_W = 24
);
  localparam int A_W = X_W + Y_W;
  localparam int F_W = C_W + Z_W + Y_W + X_W;

  logic           fifo_empty;
  logic           fifo_req;
  logic           fifo_rvalid;
  logic [F_W-1:0] fifo_rdata;

  logic           zmem_en;
  logic           zmem_we;
  logic [A_W-1:0] zmem_addr;
  logic [Z_W-1:0] zmem_wdata;
  logic [Z_W-1:0] zmem_rdata;

  logic           fb_we;
  logic [A_W-1:0] fb_addr;
  logic [C_W-1:0] fb_wdata;

  modport master (
    input  fifo_empty, fifo_rvalid, fifo_rdata, zmem_rdata,
    output fifo_req, zmem_en, zmem_we, zmem_addr, zmem_wdata,
           fb_we, fb_addr, fb_wdata
  );

  modport slave (
    output fifo_empty, fifo_rvalid, fifo_rdata, zmem_rdata,
    input  fifo_req, zmem_en, zmem_we, zmem_addr, zmem_wdata,
           fb_we, fb_addr, fb_wdata
  );

endinterface

// File: rtl/zbuf_sat_counter.sv
// Statistics counter that increments on inc_i and sticks at all ones.
module zbuf_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  // NOTE: clocked state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/zbuffer_depth_test.sv
// Pops fragments from the FIFO, depth-tests them against Z-memory and writes
// passing fragments to Z-memory and the frame buffer; also clears Z to far.
module zbuffer_depth_test
  import zbuf_pkg::*;
#(
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int Z_W      = Z_W_DEF,
  parameter int C_W      = C_W_DEF,
  parameter int DEPTH_LE = 0,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_start,
  output logic                 clear_done,
  output logic                 busy,
  zbuffer_depth_test_if.master bus,
  output logic [CNT_W-1:0]     pass_count,
  output logic [CNT_W-1:0]     fail_count
);

  localparam int A_W = X_W + Y_W;

  typedef struct packed {
    logic [C_W-1:0] color;
    logic [Z_W-1:0] z;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } frag_p_t;

  state_e         state_q, state_d;
  logic           clr_pend_q, clr_pend_d;
  logic [A_W-1:0] clr_addr_q, clr_addr_d;
  frag_p_t        frag_q, frag_d;

  logic           depth_pass;
  logic           pass_inc;
  logic           fail_inc;
  logic [A_W-1:0] pix_addr;

  assign pix_addr   = {frag_q.y, frag_q.x};
  assign depth_pass = (DEPTH_LE != 0) ? (frag_q.z <= bus.zmem_rdata)
                                      : (frag_q.z <  bus.zmem_rdata);
  assign busy       = (state_q != ST_IDLE) || clr_pend_q;

  // NOTE: every output and next-state value gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    clr_addr_d     = clr_addr_q;
    frag_d         = frag_q;
    clr_pend_d     = clr_pend_q | clear_start;
    bus.fifo_req   = 1'b0;
    bus.zmem_en    = 1'b0;
    bus.zmem_we    = 1'b0;
    bus.zmem_addr  = '0;
    bus.zmem_wdata = '0;
    bus.fb_we      = 1'b0;
    bus.fb_addr    = '0;
    bus.fb_wdata   = '0;
    clear_done     = 1'b0;
    pass_inc       = 1'b0;
    fail_inc       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (clr_pend_q) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end else if (!bus.fifo_empty) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        bus.fifo_req = 1'b1;
        state_d      = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (bus.fifo_rvalid) begin
          frag_d  = frag_p_t'(bus.fifo_rdata);
          state_d = ST_ZREAD;
        end
      end
      ST_ZREAD: begin
        bus.zmem_en   = 1'b1;
        bus.zmem_addr = pix_addr;
        state_d       = ST_ZCMP;
      end
      ST_ZCMP: begin
        if (depth_pass) begin
          state_d = ST_WRITE;
        end else begin
          fail_inc = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_WRITE: begin
        bus.zmem_en    = 1'b1;
        bus.zmem_we    = 1'b1;
        bus.zmem_addr  = pix_addr;
        bus.zmem_wdata = frag_q.z;
        bus.fb_we      = 1'b1;
        bus.fb_addr    = pix_addr;
        bus.fb_wdata   = frag_q.color;
        pass_inc       = 1'b1;
        state_d        = ST_IDLE;
      end
      ST_CLEAR: begin
        bus.zmem_en    = 1'b1;
        bus.zmem_we    = 1'b1;
        bus.zmem_addr  = clr_addr_q;
        bus.zmem_wdata = '1;
        clr_addr_d     = clr_addr_q + A_W'(1);
        // Requests arriving on the final clear cycle are absorbed by this clear.
        if (clr_addr_q == '1) begin
          clear_done = 1'b1;
          clr_pend_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      clr_pend_q <= 1'b0;
      clr_addr_q <= '0;
      frag_q     <= '0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      clr_addr_q <= clr_addr_d;
      frag_q     <= frag_d;
    end
  end

  zbuf_sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (pass_inc),
    .count_o (pass_count)
  );

  zbuf_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (fail_inc),
    .count_o (fail_count)
  );

endmodule

// File: tb/tb_zbuffer_depth_test.sv
// Bench for zbuffer_depth_test: a full-size strict-compare instance and a
// 4x4 less-or-equal instance with 3-bit counters for clear and saturation.
module tb_zbuffer_depth_test;
  import zbuf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        clr_a, clr_b, done_a, done_b, busy_a, busy_b;
  logic [15:0] pc_a, fc_a;
  logic [2:0]  pc_b, fc_b;

  zbuffer_depth_test_if #(.X_W(8), .Y_W(8), .Z_W(16), .C_W(24)) ifa ();
  zbuffer_depth_test_if #(.X_W(2), .Y_W(2), .Z_W(16), .C_W(24)) ifb ();

  zbuffer_depth_test #(.X_W(8), .Y_W(8), .Z_W(16), .C_W(24), .DEPTH_LE(0), .CNT_W(16)) dut_a (
    .clk(clk), .reset(rst), .clear_start(clr_a), .clear_done(done_a), .busy(busy_a),
    .bus(ifa), .pass_count(pc_a), .fail_count(fc_a)
  );

  zbuffer_depth_test #(.X_W(2), .Y_W(2), .Z_W(16), .C_W(24), .DEPTH_LE(1), .CNT_W(3)) dut_b (
    .clk(clk), .reset(rst), .clear_start(clr_b), .clear_done(done_b), .busy(busy_b),
    .bus(ifb), .pass_count(pc_b), .fail_count(fc_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  typedef struct {
    logic [15:0] addr;
    logic [15:0] z;
    logic [23:0] c;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  wr_t ea, eb;

  logic [15:0] mem_a [65536];
  logic [15:0] mem_b [16];

  int exp_pc_a = 0, exp_fc_a = 0, exp_pc_b = 0, exp_fc_b = 0;
  int clr_exp_b = 0, done_cnt_b = 0, stray_done_b = 0, exp_done_b = 0, done_cnt_a = 0;

  // Z-memory models: one-cycle read latency.
  always @(posedge clk) begin
    if (ifa.zmem_en) begin
      if (ifa.zmem_we) mem_a[ifa.zmem_addr] <= ifa.zmem_wdata;
      else             ifa.zmem_rdata       <= mem_a[ifa.zmem_addr];
    end
    if (ifb.zmem_en) begin
      if (ifb.zmem_we) mem_b[ifb.zmem_addr] <= ifb.zmem_wdata;
      else             ifb.zmem_rdata       <= mem_b[ifb.zmem_addr];
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (done_a) done_cnt_a++;
      if (ifa.zmem_en && ifa.zmem_we) check("a_zwr_has_fb", ifa.fb_we, 1);
      if (ifa.fb_we) begin
        check("a_wr_queued", qa.size() > 0, 1);
        if (qa.size() > 0) begin
          ea = qa.pop_front();
          check("a_zaddr", ifa.zmem_addr, ea.addr);
          check("a_fbaddr", ifa.fb_addr, ea.addr);
          check("a_zdata", ifa.zmem_wdata, ea.z);
          check("a_color", ifa.fb_wdata, ea.c);
          check("a_zwe", ifa.zmem_en && ifa.zmem_we, 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      clr_exp_b = 0;
    end else if (ifb.fb_we) begin
      check("b_wr_queued", qb.size() > 0, 1);
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        check("b_zaddr", ifb.zmem_addr, eb.addr);
        check("b_fbaddr", ifb.fb_addr, eb.addr);
        check("b_zdata", ifb.zmem_wdata, eb.z);
        check("b_color", ifb.fb_wdata, eb.c);
        check("b_zwe", ifb.zmem_en && ifb.zmem_we, 1);
      end
    end else if (ifb.zmem_en && ifb.zmem_we) begin
      check("b_clr_addr", ifb.zmem_addr, clr_exp_b);
      check("b_clr_data", ifb.zmem_wdata, 16'hFFFF);
      check("b_clr_after_frag", qb.size(), 0);
      check("b_clr_done_pos", done_b, clr_exp_b == 15);
      if (done_b) begin
        done_cnt_b++;
        clr_exp_b = 0;
      end else begin
        clr_exp_b++;
      end
    end else if (done_b) begin
      stray_done_b++;
    end
  end

  task automatic run_frag(input bit sel, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] z, input logic [23:0] c,
                          input bit exp_pass, input int delay, input int clr_at);
    wr_t   e;
    bit    got;
    int    n;
    string p;
    p = sel ? "b" : "a";
    if (sel) ifb.fifo_empty = 1'b0; else ifa.fifo_empty = 1'b0;
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = sel ? ifb.fifo_req : ifa.fifo_req;
      n++;
    end
    check({p, "_req_seen"}, got, 1);
    if (sel) ifb.fifo_empty = 1'b1; else ifa.fifo_empty = 1'b1;
    if (!got) return;

    if (exp_pass) begin
      e.addr = sel ? {12'h000, y[1:0], x[1:0]} : {y, x};
      e.z    = z;
      e.c    = c;
      if (sel) qb.push_back(e); else qa.push_back(e);
    end

    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      clr_b = (sel && i == clr_at);
      check({p, "_wait_no_req"}, sel ? ifb.fifo_req : ifa.fifo_req, 0);
      check({p, "_wait_state"}, sel ? (dut_b.state_q == ST_WAIT_DATA)
                                    : (dut_a.state_q == ST_WAIT_DATA), 1);
    end
    if (sel) begin
      ifb.fifo_rvalid = 1'b1;
      ifb.fifo_rdata  = {c, z, y[1:0], x[1:0]};
    end else begin
      ifa.fifo_rvalid = 1'b1;
      ifa.fifo_rdata  = {c, z, y, x};
    end
    @(negedge clk);
    ifa.fifo_rvalid = 1'b0;
    ifb.fifo_rvalid = 1'b0;
    clr_b           = 1'b0;
    repeat (3) @(negedge clk);

    if (sel) begin
      if (exp_pass) exp_pc_b = sat_inc(exp_pc_b, 7); else exp_fc_b = sat_inc(exp_fc_b, 7);
      check("b_pass_count", pc_b, exp_pc_b);
      check("b_fail_count", fc_b, exp_fc_b);
      check("b_queue_drained", qb.size(), 0);
    end else begin
      if (exp_pass) exp_pc_a = sat_inc(exp_pc_a, 65535); else exp_fc_a = sat_inc(exp_fc_a, 65535);
      check("a_pass_count", pc_a, exp_pc_a);
      check("a_fail_count", fc_a, exp_fc_a);
      check("a_queue_drained", qa.size(), 0);
    end
  endtask

  task automatic pulse_clear_b();
    @(negedge clk);
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
  endtask

  task automatic wait_done_b();
    int start;
    int n;
    start = done_cnt_b;
    n     = 0;
    while (done_cnt_b == start && n < 60) begin
      @(posedge clk);
      n++;
    end
    exp_done_b++;
    check("b_clear_done_seen", done_cnt_b, exp_done_b);
  endtask

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] z;
    logic [23:0] c;
    bit          pass;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int  reqs;
    int  n;
    int  wr_after;
    bit  seen;

    // Strict compare on an all-far buffer: equal and greater depths are rejected.
    vecs[0] = '{8'h03, 8'h02, 16'h1000, 24'hAABBCC, 1'b1};
    vecs[1] = '{8'h03, 8'h02, 16'h1000, 24'h111111, 1'b0};
    vecs[2] = '{8'h03, 8'h02, 16'h0FFF, 24'h222222, 1'b1};
    vecs[3] = '{8'h03, 8'h02, 16'h1000, 24'h333333, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 16'hFFFF, 24'h444444, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 16'hFFFE, 24'h555555, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 16'h0000, 24'h666666, 1'b1};
    vecs[7] = '{8'hFF, 8'hFF, 16'h0000, 24'h777777, 1'b0};
    vecs[8] = '{8'h10, 8'h80, 16'h8000, 24'h888888, 1'b1};
    vecs[9] = '{8'h10, 8'h80, 16'h7FFF, 24'h999999, 1'b1};

    ifa.fifo_empty = 1'b1; ifa.fifo_rvalid = 1'b0; ifa.fifo_rdata = '0;
    ifb.fifo_empty = 1'b1; ifb.fifo_rvalid = 1'b0; ifb.fifo_rdata = '0;
    clr_a = 1'b0;
    clr_b = 1'b0;
    for (int i = 0; i < 65536; i++) mem_a[i] = 16'hFFFF;
    for (int i = 0; i < 16; i++)    mem_b[i] = 16'hFFFF;

    repeat (2) @(negedge clk);
    check("rst_fifo_req", ifa.fifo_req, 0);
    check("rst_zmem_en", ifa.zmem_en, 0);
    check("rst_zmem_addr", ifa.zmem_addr, 0);
    check("rst_fb_we", ifb.fb_we, 0);
    check("rst_clear_done", done_b, 0);
    check("rst_busy", {busy_a, busy_b}, 0);
    check("rst_counts", {pc_a, fc_a, pc_b, fc_b}, 0);
    rst = 1'b0;

    reqs = 0;
    repeat (20) begin
      @(negedge clk);
      reqs += int'(ifa.fifo_req) + int'(ifb.fifo_req);
    end
    check("no_req_when_empty", reqs, 0);

    foreach (vecs[i])
      run_frag(1'b0, vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].c, vecs[i].pass, i % 3, -1);

    pulse_clear_b();
    wait_done_b();

    run_frag(1'b1, 8'd3, 8'd2, 16'h1000, 24'h0000A1, 1'b1, 0, -1);
    run_frag(1'b1, 8'd3, 8'd2, 16'h1000, 24'h0000A2, 1'b1, 3, -1);
    run_frag(1'b1, 8'd3, 8'd2, 16'h1001, 24'h0000A3, 1'b0, 1, -1);

    run_frag(1'b1, 8'd1, 8'd1, 16'h2000, 24'h0000B1, 1'b1, 3, 1);
    wait_done_b();

    for (int i = 0; i < 8; i++)
      run_frag(1'b1, 8'd2, 8'd0, 16'h0000, 24'hC00000 + 24'(i), 1'b1, 0, -1);
    run_frag(1'b1, 8'd0, 8'd1, 16'h0001, 24'h0000D0, 1'b1, 0, -1);
    for (int i = 0; i < 8; i++)
      run_frag(1'b1, 8'd0, 8'd1, 16'h0002, 24'h0000D1, 1'b0, 0, -1);

    check("a_no_clear_done", done_cnt_a, 0);
    check("b_stray_done", stray_done_b, 0);
    check("b_done_total", done_cnt_b, 2);

    pulse_clear_b();
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      seen = ifb.zmem_en && ifb.zmem_we && (ifb.zmem_addr == 4'd5);
      n++;
    end
    check("b_reached_addr5", seen, 1);
    rst = 1'b1;
    #1;
    check("midclr_rst_zmem_en", ifb.zmem_en, 0);
    check("midclr_rst_zmem_we", ifb.zmem_we, 0);
    check("midclr_rst_busy", busy_b, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr_after = 0;
    repeat (20) begin
      @(negedge clk);
      wr_after += int'(ifb.zmem_en);
    end
    check("post_rst_no_zmem", wr_after, 0);
    check("post_rst_busy", busy_b, 0);
    check("post_rst_no_done", done_cnt_b, exp_done_b);
    check("post_rst_counts", {pc_a, fc_a, pc_b, fc_b}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
